// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches under a credit limit,
// and buffers in-order responses tagged with their PC for the decoder.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; a
// producer holds valid and its payload stable until then, except that i_redirect may withdraw them.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          armed;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   buf_inst [FIFO_DEPTH];
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic [CW:0]   credit_used;
  logic          req_fire, push, pop;
  logic [31:0]   rsp_pc;

  assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
  // The oldest in-flight request is 'outstanding' words behind the next fetch PC.
  assign rsp_pc          = pc - (32'(outstanding) << 2);
  assign o_imem_req_addr = pc;
  assign o_inst          = buf_inst[rd_ptr];
  assign o_inst_pc       = buf_pc[rd_ptr];
  assign o_dbg_state     = state;

  always_comb begin
    o_imem_req_valid = armed && (state == RUN) && !i_redirect && (credit_used < DEPTH_W);
    req_fire         = o_imem_req_valid && i_imem_req_ready;
    o_inst_valid     = (fifo_count != '0) && !i_redirect;
    pop              = o_inst_valid && i_inst_ready;
    push             = i_imem_rsp_valid && (state == RUN) && !i_redirect;
    outstanding_nxt  = outstanding + CW'(req_fire) - CW'(i_imem_rsp_valid);
    discard_nxt      = discard;
    state_nxt        = state;
    if (i_redirect) begin
      // Everything still in flight after this edge belongs to the abandoned path.
      discard_nxt = outstanding_nxt;
      state_nxt   = (outstanding_nxt != '0) ? FLUSH : RUN;
    end else if ((state == FLUSH) && i_imem_rsp_valid) begin
      discard_nxt = discard - 1'b1;
      if (discard == CW'(1)) state_nxt = RUN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      armed       <= 1'b0;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      armed       <= 1'b1;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (i_redirect)    pc <= i_redirect_pc & 32'hFFFF_FFFC;
      else if (req_fire) pc <= pc + 32'd4;
      if (i_redirect) begin
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        // Credit accounting guarantees a free slot for every push.
        if (push) begin
          buf_inst[wr_ptr] <= i_imem_rsp_data;
          buf_pc[wr_ptr]   <= rsp_pc;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FORMAL
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_imem_rsp_valid && (outstanding == '0)));
      assert (credit_used <= DEPTH_W);
      assert (discard <= outstanding);
      assert (o_imem_req_addr[1:0] == 2'b00);
    end
  end
`endif

endmodule
